// File: rtl/serial_add_pkg.sv
// Purpose: shared definitions for the bit-serial adder (serial_add_seq).
// Contents:
//   state_t  - FSM state encoding. ST_BAD (2'd3) is never entered in
//              normal flow; the FSM steers it back to ST_IDLE.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_BAD  = 2'd3
  } state_t;

endpackage

// File: rtl/half_add_cell.sv
// Purpose: single-bit half adder. Two of these form the full-adder step of
// the bit-serial adder.
// Ports:
//   x, y  in   operand bits
//   s     out  sum bit   (x ^ y)
//   c     out  carry bit (x & y)
module half_add_cell (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/serial_add_seq.sv
// Purpose: bit-serial WIDTH-bit adder. Accepts an operand pair over a
// valid/ready handshake, adds LSB-first one bit per clock, and presents
// sum/cout over a second valid/ready handshake.
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE, out_valid only in DONE; both
// are decoded from registered state, so neither depends on in_valid or
// out_ready combinationally.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    operand handshake; a, b sampled on accept
//   a, b                 WIDTH-bit operands
//   out_valid/out_ready  result handshake
//   sum                  (a+b) mod 2^WIDTH, held until the next result
//   cout                 carry out of bit WIDTH-1
//   busy                 high while bits are being added (RUN)
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry;
  logic [CW-1:0]    count;

  logic ha0_s, ha0_c, ha1_s, ha1_c;
  logic bit_s, bit_c;
  logic accept, last_step, release_out;

  // Full-adder step built from two half adders; carry out is the OR of the
  // two half carries (they can never both be 1).
  half_add_cell u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(ha0_s), .c(ha0_c));
  half_add_cell u_ha1 (.x(ha0_s),   .y(carry),   .s(ha1_s), .c(ha1_c));

  assign bit_s = ha1_s;
  assign bit_c = ha0_c | ha1_c;

  assign accept      = (state == ST_IDLE) && in_valid;
  assign last_step   = (state == ST_RUN) && (count == LAST);
  assign release_out = (state == ST_DONE) && out_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)      state_nxt = ST_RUN;
      ST_RUN:  if (last_step)   state_nxt = ST_DONE;
      ST_DONE: if (release_out) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      s_sh   <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      carry  <= 1'b0;
      count  <= '0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= 1'b0;
      count <= '0;
    end else if (state == ST_RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= {bit_s, s_sh[WIDTH-1:1]};
      carry <= bit_c;
      // Hold at the last index so count never wraps.
      if (!last_step) count <= count + CW'(1);
      // Result is captured into its own register so it stays put through
      // the next operation until a new result replaces it.
      if (last_step) begin
        sum_q  <= {bit_s, s_sh[WIDTH-1:1]};
        cout_q <= bit_c;
      end
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_RUN);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq: an 8-bit instance carries most of the
// sequence, a 4-bit instance covers the narrow-width and back-to-back cases.
module tb_serial_add_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       in_valid, in_ready, out_valid, out_ready, busy, cout;
  logic [7:0] a, b, sum;
  // 4-bit instance
  logic       w4_in_valid, w4_in_ready, w4_out_valid, w4_out_ready, w4_busy, w4_cout;
  logic [3:0] w4_a, w4_b, w4_sum;

  serial_add_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_add_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
    .a(w4_a), .b(w4_b), .out_valid(w4_out_valid), .out_ready(w4_out_ready),
    .sum(w4_sum), .cout(w4_cout), .busy(w4_busy)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];   // {cout, sum} for the 8-bit instance
  logic [4:0] exp4_q[$];  // {cout, sum} for the 4-bit instance

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic [8:0] exp);
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    a = x; b = y; in_valid = 1'b1;
    exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  // Called right after the accept edge; counts edges until out_valid.
  task automatic wait_result8(input string tag);
    int n = 0;
    logic [8:0] e;
    while (!out_valid && n < 100) begin tick(); n++; end
    check({tag, "_latency"}, n, 32'd8);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 9'h1XX;
    check({tag, "_result"}, {23'd0, cout, sum}, {23'd0, e});
  endtask

  task automatic release8(input string tag);
    out_ready = 1'b1;
    tick();
    check({tag, "_in_ready_after_release"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_out_valid_after_release"}, {31'd0, out_valid}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int t0;
    logic [8:0] hold_res;
    logic [4:0] e4;

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    w4_in_valid = 1'b0; w4_out_ready = 1'b1; w4_a = '0; w4_b = '0;
    #1;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_sum_cout",  {23'd0, cout, sum}, 32'd0);
    check("rst_w4_state",  {29'd0, w4_in_ready, w4_out_valid, w4_busy}, 32'd4);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1) 0F + 01
    send8(8'h0F, 8'h01, 9'h010);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_in_ready_run", {31'd0, in_ready}, 32'd0);
    wait_result8("t1");
    release8("t1");

    // 2) carry chain and no-carry patterns
    send8(8'hFF, 8'h01, 9'h100);
    wait_result8("t2a");
    release8("t2a");
    send8(8'hAA, 8'h55, 9'h0FF);
    wait_result8("t2b");
    release8("t2b");

    // 3) backpressure: hold DONE for 5 cycles, in_valid high during release
    out_ready = 1'b0;
    send8(8'h80, 8'h80, 9'h100);
    wait_result8("t3");
    hold_res = {cout, sum};
    in_valid = 1'b1; a = 8'h11; b = 8'h22;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("t3_hold_in_ready",  {31'd0, in_ready},  32'd0);
      check("t3_hold_result",    {23'd0, cout, sum}, {23'd0, hold_res});
    end
    out_ready = 1'b1;
    tick();
    // Release edge must not also accept the waiting operands.
    check("t3_release_in_ready", {31'd0, in_ready}, 32'd1);
    check("t3_release_busy",     {31'd0, busy},     32'd0);
    in_valid = 1'b0;
    tick();
    check("t3_idle_stays", {30'd0, in_ready, busy}, 32'd2);

    // 4) in_valid during RUN is ignored
    send8(8'h12, 8'h34, 9'h046);
    in_valid = 1'b1; a = 8'h33; b = 8'h33;
    wait_result8("t4");
    in_valid = 1'b0;
    release8("t4");
    check("t4_no_extra_accept", {31'd0, busy}, 32'd0);

    // 5) async reset mid-RUN
    send8(8'hFF, 8'hFF, 9'h1FE);
    tick(); tick();
    check("t5_busy_before_rst", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("t5_rst_busy",      {31'd0, busy},      32'd0);
    check("t5_rst_sum_cout",  {23'd0, cout, sum}, 32'd0);
    exp_q.delete();
    #3 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t5_no_output_after_rst", {31'd0, out_valid}, 32'd0);
    end
    send8(8'h02, 8'h03, 9'h005);
    wait_result8("t5");
    release8("t5");

    // 6) WIDTH=4: F + F, latency 4
    w4_a = 4'hF; w4_b = 4'hF; w4_in_valid = 1'b1;
    exp4_q.push_back(5'h1E);
    tick();
    w4_in_valid = 1'b0;
    n = 0;
    while (!w4_out_valid && n < 100) begin tick(); n++; end
    check("t6_latency", n, 32'd4);
    e4 = (exp4_q.size() > 0) ? exp4_q.pop_front() : 5'h00;
    check("t6_result", {27'd0, w4_cout, w4_sum}, {27'd0, e4});
    tick();
    check("t6_release", {31'd0, w4_in_ready}, 32'd1);

    // 6b) back-to-back with in_valid and out_ready held high
    w4_a = 4'h7; w4_b = 4'h9; w4_in_valid = 1'b1;
    exp4_q.push_back(5'h10);
    exp4_q.push_back(5'h07);
    n = 0;
    while (!w4_out_valid && n < 100) begin tick(); n++; end
    check("t6b_first_latency", n, 32'd5);
    e4 = (exp4_q.size() > 0) ? exp4_q.pop_front() : 5'h00;
    check("t6b_first_result", {27'd0, w4_cout, w4_sum}, {27'd0, e4});
    w4_a = 4'h3; w4_b = 4'h4;
    t0 = 0;
    do begin tick(); t0++; end while (!w4_out_valid && t0 < 100);
    check("t6b_spacing", t0, 32'd6);
    e4 = (exp4_q.size() > 0) ? exp4_q.pop_front() : 5'h00;
    check("t6b_second_result", {27'd0, w4_cout, w4_sum}, {27'd0, e4});
    w4_in_valid = 1'b0;
    tick();

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
